// File: rtl/crypt_session_if.sv
// Session controller bundle: requests, symbol stream, key store port and session status.
interface crypt_session_if #(
   parameter int unsigned KEY_W = 2,
   parameter int unsigned LEN_W = 4
);
   logic             req_enc;
   logic             req_dec;
   logic [LEN_W-1:0] len;
   logic             in_valid;
   logic [1:0]       in_sym;
   logic             in_ready;
   logic [1:0]       key_sym;
   logic [KEY_W-1:0] key_idx;
   logic             out_valid;
   logic [1:0]       out_sym;
   logic [1:0]       grant;
   logic             busy;
   logic             done;

   // Requesters, symbol source and key store side.
   modport master (
      output req_enc, req_dec, len, in_valid, in_sym, key_sym,
      input  in_ready, key_idx, out_valid, out_sym, grant, busy, done
   );

   // Controller side.
   modport slave (
      input  req_enc, req_dec, len, in_valid, in_sym, key_sym,
      output in_ready, key_idx, out_valid, out_sym, grant, busy, done
   );
endinterface

// File: rtl/crypt_session_ctrl.sv
// crypt_session_ctrl: round-robin grant of the 2-bit cipher path to the encrypt or
// decrypt requester, then one framed message per grant: 2 clear header symbols
// (00, 01) followed by len+1 payload symbols XORed with a cycling key.
module crypt_session_ctrl #(
   parameter int unsigned KEY_LEN = 4,
   parameter int unsigned KEY_W   = 2,
   parameter int unsigned LEN_W   = 4
) (
   input logic            clock,
   input logic            reset,
   crypt_session_if.slave bus
);
   typedef enum logic [2:0] {StIdle, StHdr0, StHdr1, StPayload, StDone} state_e;

   localparam logic [KEY_W-1:0] KeyLast  = KEY_W'(KEY_LEN - 1);
   localparam logic [1:0]       GrantEnc = 2'b01;
   localparam logic [1:0]       GrantDec = 2'b10;

   state_e           state_q, state_d;
   logic [1:0]       grant_q, grant_d;
   logic [1:0]       last_grant_q, last_grant_d;
   logic [LEN_W-1:0] rem_cnt_q, rem_cnt_d;
   logic [KEY_W-1:0] key_idx_q, key_idx_d;
   logic             out_valid_q, out_valid_d;
   logic [1:0]       out_sym_q, out_sym_d;
   logic             in_ready;
   logic             accept;
   logic             pick_enc;

   assign in_ready = (state_q == StHdr0) || (state_q == StHdr1) || (state_q == StPayload);
   assign accept   = bus.in_valid & in_ready;
   // Enc wins alone, or on a tie when dec held the path last.
   assign pick_enc = bus.req_enc & (~bus.req_dec | last_grant_q[1]);

   // Next-state: arbitration, header tracking, payload ciphering and key stepping.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      rem_cnt_d    = rem_cnt_q;
      key_idx_d    = key_idx_q;
      out_valid_d  = 1'b0;
      out_sym_d    = out_sym_q;
      unique case (state_q)
         StIdle: begin
            if (bus.req_enc | bus.req_dec) begin
               grant_d   = pick_enc ? GrantEnc : GrantDec;
               rem_cnt_d = bus.len;
               key_idx_d = pick_enc ? '0 : KeyLast;
               state_d   = StHdr0;
            end
         end
         StHdr0: begin
            if (accept) begin
               out_valid_d = 1'b1;
               out_sym_d   = bus.in_sym;
               if (bus.in_sym == 2'b00) state_d = StHdr1;
            end
         end
         StHdr1: begin
            if (accept) begin
               out_valid_d = 1'b1;
               out_sym_d   = bus.in_sym;
               // A repeated 00 may itself be the start of the header.
               if (bus.in_sym == 2'b01)      state_d = StPayload;
               else if (bus.in_sym != 2'b00) state_d = StHdr0;
            end
         end
         StPayload: begin
            if (accept) begin
               out_valid_d = 1'b1;
               out_sym_d   = bus.in_sym ^ bus.key_sym;
               rem_cnt_d   = rem_cnt_q - LEN_W'(1);
               if (grant_q[0]) key_idx_d = (key_idx_q == KeyLast) ? '0 : key_idx_q + KEY_W'(1);
               else            key_idx_d = (key_idx_q == '0) ? KeyLast : key_idx_q - KEY_W'(1);
               if (rem_cnt_q == '0) state_d = StDone;
            end
         end
         StDone: begin
            last_grant_d = grant_q;
            grant_d      = '0;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; dec counts as last grant so enc wins the first tie.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         last_grant_q <= GrantDec;
         rem_cnt_q    <= '0;
         key_idx_q    <= '0;
         out_valid_q  <= 1'b0;
         out_sym_q    <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         rem_cnt_q    <= rem_cnt_d;
         key_idx_q    <= key_idx_d;
         out_valid_q  <= out_valid_d;
         out_sym_q    <= out_sym_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.key_idx   = key_idx_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sym   = out_sym_q;
   assign bus.grant     = grant_q;
   assign bus.busy      = (state_q != StIdle);
   assign bus.done      = (state_q == StDone);
endmodule

// File: tb/tb_crypt_session_ctrl.sv
// Directed bench for crypt_session_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_crypt_session_ctrl;
   logic       clock = 1'b0;
   logic       reset;
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [1:0] key_mem [4];

   crypt_session_if #(.KEY_W(2), .LEN_W(4)) bus ();

   crypt_session_ctrl #(.KEY_LEN(4), .KEY_W(2), .LEN_W(4)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   // Free-running clock, period 10.
   always #5 clock = ~clock;

   assign bus.key_sym = key_mem[bus.key_idx];

   task automatic drive_idle();
      bus.req_enc  = 1'b0;
      bus.req_dec  = 1'b0;
      bus.len      = 4'd0;
      bus.in_valid = 1'b0;
      bus.in_sym   = 2'd0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive_idle();
      repeat (2) @(negedge clock);
      n_checks++;
      if ({bus.grant, bus.out_valid, bus.busy, bus.done, bus.in_ready} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got grant/ov/busy/done/rdy=%b expected 000000",
                  {bus.grant, bus.out_valid, bus.busy, bus.done, bus.in_ready});
      end
      n_checks++;
      if ({bus.key_idx, bus.out_sym} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_data: got key_idx/out_sym=%b expected 0000",
                  {bus.key_idx, bus.out_sym});
      end
      reset = 1'b0;
      @(negedge clock);
      n_checks++;
      if ({bus.grant, bus.busy} !== 3'b0) begin
         n_fail++;
         $display("FAIL reset_release: got grant/busy=%b expected 000", {bus.grant, bus.busy});
      end
   endtask

   task automatic test_enc_session();
      logic [1:0] syms [5];
      logic [1:0] outs [5];
      syms = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
      outs = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
      bus.req_enc = 1'b1;
      bus.len     = 4'd2;
      @(negedge clock);
      n_checks++;
      if ({bus.grant, bus.key_idx, bus.busy, bus.in_ready} !== {2'b01, 2'd0, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL enc_grant: got grant/key_idx/busy/rdy=%b expected 01001 1",
                  {bus.grant, bus.key_idx, bus.busy, bus.in_ready});
      end
      bus.req_enc = 1'b0;
      bus.len     = 4'd0;  // must not shorten the running session
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.in_sym   = syms[i];
         @(negedge clock);
         n_checks++;
         if ({bus.out_valid, bus.out_sym, bus.done} !== {1'b1, outs[i], i == 4}) begin
            n_fail++;
            $display("FAIL enc_out[%0d]: got ov/sym/done=%b expected %b", i,
                     {bus.out_valid, bus.out_sym, bus.done}, {1'b1, outs[i], i == 4});
         end
      end
      n_checks++;
      if ({bus.in_ready, bus.grant} !== 3'b001) begin
         n_fail++;
         $display("FAIL enc_done_state: got rdy/grant=%b expected 001", {bus.in_ready, bus.grant});
      end
      bus.in_valid = 1'b0;
      @(negedge clock);
      n_checks++;
      if ({bus.done, bus.grant, bus.busy, bus.out_valid} !== 5'b0) begin
         n_fail++;
         $display("FAIL enc_end: got done/grant/busy/ov=%b expected 00000",
                  {bus.done, bus.grant, bus.busy, bus.out_valid});
      end
   endtask

   task automatic test_dec_session();
      logic [1:0] syms [3];
      syms = '{2'd0, 2'd1, 2'd2};
      bus.req_dec = 1'b1;
      bus.len     = 4'd0;
      @(negedge clock);
      n_checks++;
      if ({bus.grant, bus.key_idx} !== {2'b10, 2'd3}) begin
         n_fail++;
         $display("FAIL dec_grant: got grant/key_idx=%b expected 1011", {bus.grant, bus.key_idx});
      end
      bus.req_dec = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_sym   = syms[i];
         @(negedge clock);
         n_checks++;
         if ({bus.out_valid, bus.out_sym, bus.done} !== {1'b1, syms[i], i == 2}) begin
            n_fail++;
            $display("FAIL dec_out[%0d]: got ov/sym/done=%b expected %b", i,
                     {bus.out_valid, bus.out_sym, bus.done}, {1'b1, syms[i], i == 2});
         end
      end
      n_checks++;
      if (bus.key_idx !== 2'd2) begin
         n_fail++;
         $display("FAIL dec_key_step: got key_idx=%0d expected 2", bus.key_idx);
      end
      bus.in_valid = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_arbitration();
      logic [1:0] exp_grant [3];
      logic [1:0] exp_out   [3];
      exp_grant = '{2'b01, 2'b10, 2'b01};
      exp_out   = '{2'd1, 2'd2, 2'd1};  // payload 2 ^ key[0]=3 for enc, ^ key[3]=0 for dec
      bus.req_enc = 1'b1;
      bus.req_dec = 1'b1;
      bus.len     = 4'd0;
      @(negedge clock);
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (bus.grant !== exp_grant[k]) begin
            n_fail++;
            $display("FAIL arb_grant[%0d]: got %b expected %b", k, bus.grant, exp_grant[k]);
         end
         for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sym   = (i == 2) ? 2'd2 : 2'(i);
            @(negedge clock);
         end
         n_checks++;
         if ({bus.out_valid, bus.out_sym, bus.done, bus.grant} !==
             {1'b1, exp_out[k], 1'b1, exp_grant[k]}) begin
            n_fail++;
            $display("FAIL arb_done[%0d]: got ov/sym/done/grant=%b expected %b", k,
                     {bus.out_valid, bus.out_sym, bus.done, bus.grant},
                     {1'b1, exp_out[k], 1'b1, exp_grant[k]});
         end
         if (k == 2) begin
            bus.req_enc = 1'b0;
            bus.req_dec = 1'b0;
         end
         bus.in_valid = 1'b0;
         @(negedge clock);
         n_checks++;
         if ({bus.grant, bus.busy} !== 3'b0) begin
            n_fail++;
            $display("FAIL arb_gap[%0d]: got grant/busy=%b expected 000", k, {bus.grant, bus.busy});
         end
         @(negedge clock);
      end
   endtask

   task automatic test_header_recovery();
      logic [1:0] syms_a [4];
      logic [1:0] outs_a [4];
      logic [1:0] syms_b [6];
      logic [1:0] outs_b [6];
      logic       chk_b  [6];
      syms_a = '{2'd0, 2'd0, 2'd1, 2'd1};
      outs_a = '{2'd0, 2'd0, 2'd1, 2'd2};
      syms_b = '{2'd0, 2'd3, 2'd1, 2'd0, 2'd1, 2'd3};
      outs_b = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
      chk_b  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      bus.req_enc = 1'b1;
      bus.len     = 4'd0;
      @(negedge clock);
      bus.req_enc = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_sym   = syms_a[i];
         @(negedge clock);
         n_checks++;
         if ({bus.out_valid, bus.out_sym, bus.done} !== {1'b1, outs_a[i], i == 3}) begin
            n_fail++;
            $display("FAIL hdr_overlap[%0d]: got ov/sym/done=%b expected %b", i,
                     {bus.out_valid, bus.out_sym, bus.done}, {1'b1, outs_a[i], i == 3});
         end
      end
      bus.in_valid = 1'b0;
      @(negedge clock);
      bus.req_enc = 1'b1;
      @(negedge clock);
      bus.req_enc = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.in_valid = 1'b1;
         bus.in_sym   = syms_b[i];
         @(negedge clock);
         n_checks++;
         if (bus.done !== (i == 5)) begin
            n_fail++;
            $display("FAIL hdr_restart_done[%0d]: got %b expected %b", i, bus.done, i == 5);
         end
         if (chk_b[i]) begin
            n_checks++;
            if ({bus.out_valid, bus.out_sym} !== {1'b1, outs_b[i]}) begin
               n_fail++;
               $display("FAIL hdr_restart_out[%0d]: got ov/sym=%b expected %b", i,
                        {bus.out_valid, bus.out_sym}, {1'b1, outs_b[i]});
            end
         end
      end
      bus.in_valid = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_key_wrap_stall();
      logic [1:0] psym [6];
      logic [1:0] pout [6];
      logic [1:0] kidx [6];
      logic [1:0] prev;
      psym = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
      pout = '{2'd2, 2'd3, 2'd1, 2'd0, 2'd2, 2'd3};
      kidx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      bus.req_enc = 1'b1;
      bus.len     = 4'd5;
      @(negedge clock);
      bus.req_enc  = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_sym   = 2'd0;
      @(negedge clock);
      bus.in_sym   = 2'd1;
      @(negedge clock);
      prev = 2'd1;
      for (int i = 0; i < 6; i++) begin
         bus.in_valid = 1'b0;
         bus.in_sym   = 2'd3;
         @(negedge clock);
         n_checks++;
         if ({bus.out_valid, bus.out_sym, bus.done, bus.key_idx} !== {1'b0, prev, 1'b0, kidx[i]}) begin
            n_fail++;
            $display("FAIL stall[%0d]: got ov/sym/done/key_idx=%b expected %b", i,
                     {bus.out_valid, bus.out_sym, bus.done, bus.key_idx},
                     {1'b0, prev, 1'b0, kidx[i]});
         end
         bus.in_valid = 1'b1;
         bus.in_sym   = psym[i];
         @(negedge clock);
         n_checks++;
         if ({bus.out_valid, bus.out_sym, bus.done} !== {1'b1, pout[i], i == 5}) begin
            n_fail++;
            $display("FAIL wrap_out[%0d]: got ov/sym/done=%b expected %b", i,
                     {bus.out_valid, bus.out_sym, bus.done}, {1'b1, pout[i], i == 5});
         end
         prev = pout[i];
      end
      bus.in_valid = 1'b0;
      @(negedge clock);
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_end: got busy=%b expected 0", bus.busy);
      end
   endtask

   task automatic test_reset_mid();
      bus.req_enc = 1'b1;
      bus.len     = 4'd3;
      @(negedge clock);
      bus.req_enc  = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_sym   = 2'd0;
      @(negedge clock);
      bus.in_sym   = 2'd1;
      @(negedge clock);
      bus.in_sym   = 2'd1;
      @(negedge clock);
      n_checks++;
      if ({bus.out_valid, bus.busy, bus.key_idx} !== {1'b1, 1'b1, 2'd1}) begin
         n_fail++;
         $display("FAIL mid_pre: got ov/busy/key_idx=%b expected 1101",
                  {bus.out_valid, bus.busy, bus.key_idx});
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if ({bus.grant, bus.out_valid, bus.busy, bus.done, bus.in_ready, bus.key_idx} !== 8'b0) begin
         n_fail++;
         $display("FAIL mid_reset: got grant/ov/busy/done/rdy/key_idx=%b expected 00000000",
                  {bus.grant, bus.out_valid, bus.busy, bus.done, bus.in_ready, bus.key_idx});
      end
      @(negedge clock);
      reset = 1'b0;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_checks++;
         if ({bus.done, bus.busy, bus.out_valid} !== 3'b0) begin
            n_fail++;
            $display("FAIL mid_after[%0d]: got done/busy/ov=%b expected 000", i,
                     {bus.done, bus.busy, bus.out_valid});
         end
      end
   endtask

   initial begin
      key_mem[0] = 2'd3;
      key_mem[1] = 2'd1;
      key_mem[2] = 2'd2;
      key_mem[3] = 2'd0;
      test_reset();
      test_enc_session();
      test_dec_session();
      test_arbitration();
      test_header_recovery();
      test_key_wrap_stall();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
